mix_columns_seq: RTL and testbench

//   Sequenced AES MixColumns engine for the aes256_uart round datapath.
//   - Accepts one 128-bit state word over a valid/ready handshake.
//   - Processes it NCOL columns per cycle on a shared bank of byte_mix cells.
//   - Returns the mixed state over a valid/ready handshake.
//   - last_round bypasses the mix, because the final AES round omits MixColumns.

---
 rtl/aes_pkg.sv | 34 +++
 rtl/mix_column.sv | 39 +++
 rtl/mix_columns_seq.sv | 99 +++++++++
 tb/tb_mix_columns_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, FSM encoding, and byte/column helpers.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COLS    = 4;
    localparam int AES_ROWS    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Column c occupies bits [127-32c -: 32], so its LSB sits at 32*(3-c); 3-c equals ~c for 2 bits.
    function automatic logic [6:0] col_base(input logic [1:0] c);
        return {~c, 5'b00000};
    endfunction

    // Byte (r,c) occupies bits [127-32c-8r -: 8], LSB at 8*(15-4c-r).
    function automatic logic [6:0] byte_base(input logic [1:0] r, input logic [1:0] c);
        return {~c, ~r, 3'b000};
    endfunction

    // Extract one 32-bit column, row 0 in the most significant byte.
    function automatic logic [31:0] get_col(input logic [AES_STATE_W-1:0] s, input logic [1:0] c);
        return s[col_base(c) +: 32];
    endfunction

    // Multiply by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column.sv
// One AES MixColumns column: four byte_mix cells with rotated operand order.
module byte_mix
    import aes_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic [7:0] d,
    output logic [7:0] o
);

    // 2*a ^ 3*b ^ c ^ d, where 3*b is 2*b ^ b.
    assign o = xtime(a) ^ xtime(b) ^ b ^ c ^ d;

endmodule

module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] s0;
    logic [7:0] s1;
    logic [7:0] s2;
    logic [7:0] s3;

    assign s0 = col_in[31:24];
    assign s1 = col_in[23:16];
    assign s2 = col_in[15:8];
    assign s3 = col_in[7:0];

    byte_mix u_mix0 (.a(s0), .b(s1), .c(s2), .d(s3), .o(col_out[31:24]));
    byte_mix u_mix1 (.a(s1), .b(s2), .c(s3), .d(s0), .o(col_out[23:16]));
    byte_mix u_mix2 (.a(s2), .b(s3), .c(s0), .d(s1), .o(col_out[15:8]));
    byte_mix u_mix3 (.a(s3), .b(s0), .c(s1), .d(s2), .o(col_out[7:0]));

endmodule

// File: rtl/mix_columns_seq.sv
// Sequenced MixColumns engine: NCOL columns per cycle on a shared bank of mix_column cells.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int NCOL = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    if (!(NCOL == 1 || NCOL == 2 || NCOL == 4)) begin : g_bad_ncol
        $error("mix_columns_seq: NCOL must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP  = 2'(NCOL);
    localparam logic [1:0] LAST  = 2'(AES_COLS - NCOL);

    fsm_state_t             state;
    logic [1:0]             counter;
    logic [AES_STATE_W-1:0] in_reg;
    logic [31:0]            col_in  [NCOL];
    logic [31:0]            col_out [NCOL];
    logic [AES_STATE_W-1:0] mixed_next;

    for (genvar j = 0; j < NCOL; j++) begin : g_cols
        assign col_in[j] = get_col(in_reg, counter + 2'(j));
        mix_column u_col (.col_in(col_in[j]), .col_out(col_out[j]));
    end

    // Merge the freshly mixed column group into the current result word.
    always_comb begin
        mixed_next = out_state;
        for (int j = 0; j < NCOL; j++) begin
            mixed_next[col_base(counter + 2'(j)) +: 32] = col_out[j];
        end
    end

    // Control FSM with registered handshake outputs and result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            counter   <= 2'd0;
            in_reg    <= '0;
            out_state <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_reg   <= in_state;
                        busy     <= 1'b1;
                        in_ready <= 1'b0;
                        if (in_last) begin
                            out_state <= in_state;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            counter <= 2'd0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    out_state <= mixed_next;
                    counter   <= counter + STEP;
                    if (counter == LAST) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed bench for mix_columns_seq with NCOL = 1, 2 and 4 instances side by side.
module tb_mix_columns_seq;

    localparam logic [127:0] V1  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] E1  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] E2  = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] VB  = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic         clk;
    logic         rst_n;
    logic [2:0]   in_valid;
    logic [2:0]   in_last;
    logic [2:0]   out_ready;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   busy;
    logic [127:0] in_state  [3];
    logic [127:0] out_state [3];

    int total;
    int bad;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NC = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        mix_columns_seq #(.NCOL(NC)) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .in_last   (in_last[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drives one word through instance k and records what was observed; no judging here.
    task automatic do_transaction(input int k, input logic [127:0] v, input logic last,
                                  input bit pulse, input int hold,
                                  output int lat, output logic [127:0] res,
                                  output bit ready_seen, output bit hold_ok,
                                  output logic post_valid, output logic post_ready,
                                  output logic [127:0] post_state);
        ready_seen = 0;
        hold_ok    = 1;
        @(negedge clk);
        in_state[k] = v;
        in_last[k]  = last;
        in_valid[k] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        in_state[k] = ~v;
        lat = 1;
        while (!out_valid[k] && lat < 20) begin
            if (in_ready[k]) ready_seen = 1;
            if (pulse) begin
                in_valid[k] = 1'b1;
                in_last[k]  = 1'b1;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        res = out_state[k];
        for (int i = 0; i < hold; i++) begin
            in_valid[k] = 1'b1;
            @(posedge clk);
            #1;
            if (!out_valid[k] || out_state[k] !== res || in_ready[k] !== 1'b0) hold_ok = 0;
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[k] = 1'b0;
        post_valid = out_valid[k];
        post_ready = in_ready[k];
        post_state = out_state[k];
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            total++;
            if (out_valid[k] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_out_valid inst=%0d got=%b want=0", k, out_valid[k]);
            end
            total++;
            if (in_ready[k] !== 1'b1) begin
                bad++;
                $display("[TB] FAIL reset_in_ready inst=%0d got=%b want=1", k, in_ready[k]);
            end
            total++;
            if (busy[k] !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_busy inst=%0d got=%b want=0", k, busy[k]);
            end
            total++;
            if (out_state[k] !== 128'h0) begin
                bad++;
                $display("[TB] FAIL reset_out_state inst=%0d got=%h want=0", k, out_state[k]);
            end
        end
    endtask

    task automatic test_mix(input int k, input logic [127:0] v, input logic [127:0] e,
                            input int want_lat, input bit pulse, input string name);
        int lat; logic [127:0] res; bit rs; bit hok; logic pv; logic pr; logic [127:0] ps;
        do_transaction(k, v, 1'b0, pulse, 0, lat, res, rs, hok, pv, pr, ps);
        total++;
        if (lat !== want_lat) begin
            bad++;
            $display("[TB] FAIL %s_latency got=%0d want=%0d", name, lat, want_lat);
        end
        total++;
        if (res !== e) begin
            bad++;
            $display("[TB] FAIL %s_result got=%h want=%h", name, res, e);
        end
        total++;
        if (rs) begin
            bad++;
            $display("[TB] FAIL %s_in_ready_while_busy got=1 want=0", name);
        end
        total++;
        if (pv !== 1'b0 || pr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s_handoff got valid=%b ready=%b want valid=0 ready=1", name, pv, pr);
        end
        total++;
        if (ps !== e) begin
            bad++;
            $display("[TB] FAIL %s_idle_hold got=%h want=%h", name, ps, e);
        end
    endtask

    task automatic test_bypass(input int k);
        int lat; logic [127:0] res; bit rs; bit hok; logic pv; logic pr; logic [127:0] ps;
        do_transaction(k, VB, 1'b1, 1'b0, 0, lat, res, rs, hok, pv, pr, ps);
        total++;
        if (lat !== 1) begin
            bad++;
            $display("[TB] FAIL bypass_latency inst=%0d got=%0d want=1", k, lat);
        end
        total++;
        if (res !== VB) begin
            bad++;
            $display("[TB] FAIL bypass_result inst=%0d got=%h want=%h", k, res, VB);
        end
        total++;
        if (pv !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bypass_handoff inst=%0d got=%b want=0", k, pv);
        end
    endtask

    task automatic test_backpressure();
        int lat; logic [127:0] res; bit rs; bit hok; logic pv; logic pr; logic [127:0] ps;
        do_transaction(0, V1, 1'b0, 1'b0, 7, lat, res, rs, hok, pv, pr, ps);
        total++;
        if (res !== E1) begin
            bad++;
            $display("[TB] FAIL backpressure_result got=%h want=%h", res, E1);
        end
        total++;
        if (!hok) begin
            bad++;
            $display("[TB] FAIL backpressure_stable got=unstable want=stable");
        end
        total++;
        if (pv !== 1'b0 || pr !== 1'b1) begin
            bad++;
            $display("[TB] FAIL backpressure_handoff got valid=%b ready=%b want valid=0 ready=1", pv, pr);
        end
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        in_state[0] = V1;
        in_last[0]  = 1'b0;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        total++;
        if (out_valid[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_out_valid got=%b want=0", out_valid[0]);
        end
        total++;
        if (in_ready[0] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_in_ready got=%b want=1", in_ready[0]);
        end
        total++;
        if (busy[0] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midreset_busy got=%b want=0", busy[0]);
        end
        test_mix(0, V1, E1, 5, 1'b0, "midreset_recover");
    endtask

    // Test sequence.
    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        in_valid  = '0;
        in_last   = '0;
        out_ready = '0;
        for (int k = 0; k < 3; k++) in_state[k] = '0;

        test_reset();
        test_mix(0, V1, E1, 5, 1'b0, "ncol1_v1");
        test_mix(0, V2, E2, 5, 1'b0, "ncol1_v2");
        test_bypass(0);
        test_backpressure();
        test_reset_mid_run();
        test_mix(1, V1, E1, 3, 1'b1, "ncol2_v1");
        test_mix(1, V2, E2, 3, 1'b1, "ncol2_v2");
        test_mix(2, V1, E1, 2, 1'b1, "ncol4_v1");
        test_mix(2, V2, E2, 2, 1'b1, "ncol4_v2");
        test_mix(0, V2, E2, 5, 1'b1, "ncol1_pulse");
        test_bypass(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
